fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end with a small prefetch queue. It owns the program counter and issues reads to the synchronous instruction memory. It buffers returned instructions together with their addresses and presents them to the decode stage under a valid/ready handshake. A taken jump from the memory-access stage flushes the queue and redirects the program counter.

## Interface
- ADDR_WIDTH, 4, instruction address width; the PC wraps modulo 2^ADDR_WIDTH
- INST_WIDTH, 8, instruction word width
- DEPTH, 4, queue entries; must be a power of two and at least 2

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- jump_flag  in  1  taken jump/branch this cycle (from mem-access boundary)
- jump_addr  in  ADDR_WIDTH  redirect target, valid while jump_flag=1
- imem_en  out  1  instruction memory read request (combinational)
- imem_addr  out  ADDR_WIDTH  read address; equals the PC register
- imem_data  in  INST_WIDTH  read data, valid the cycle after imem_en=1
- id_ready  in  1  decode accepts the head entry this cycle (0 = stall)
- inst_valid  out  1  queue non-empty
- inst  out  INST_WIDTH  head-entry instruction
- inst_addr  out  ADDR_WIDTH  head-entry instruction address

## Operation
- State:
  - pc register
  - inflight flag (a read was issued last cycle and is not cancelled)
  - queue of DEPTH entries {inst, addr}, with read pointer, write pointer and count (0..DEPTH)
- pop = inst_valid & id_ready.
- Issue condition:
  - imem_en = !rst & !jump_flag & (count + inflight - pop < DEPTH).
  - Occupancy credit counts the in-flight read, so the queue never overflows.
- imem_addr = pc at all times.
- On each imem_en=1 edge:
  - pc <= pc + 1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - inflight <= 1; otherwise inflight <= 0.
  - The issued address is held in a companion register so it can be stored with the returned data.
- Push: on any edge where inflight=1 and jump_flag=0, {imem_data, issued address} is written at the write pointer.
- Push and pop on the same edge:
  - Both take effect and count is unchanged.
  - This is legal at count=DEPTH only when pop=1; the credit rule guarantees that.
- Jump (jump_flag=1), on that edge:
  - pc <= jump_addr.
  - count, read pointer and write pointer <= 0.
  - inflight <= 0; a response arriving this cycle is dropped and never pushed.
  - Any pop in the same cycle is ignored for state purposes; flush wins.
- No bypass path: returned data becomes visible on inst/inst_addr one cycle after it arrives.
- inst and inst_addr always show the entry at the read pointer. While inst_valid=0 their values are don't-care for the consumer but must be deterministic: storage is reset to 0.

## Timing
- Reset (asynchronous): pc=0, inflight=0, count=0, pointers=0, all entries 0. Outputs are therefore:
  - inst_valid=0, inst=0, inst_addr=0
  - imem_addr=0
  - imem_en=0 while rst=1
- First cycle after reset release: imem_en=1, imem_addr=0.
- Fetch-to-decode latency is 2 cycles:
  - request in cycle N
  - data at imem_data in cycle N+1
  - inst_valid with that entry in cycle N+2
- Steady state with id_ready=1: one instruction per cycle, no bubbles.
- Stall with id_ready=0:
  - Requests continue until count + inflight = DEPTH, then imem_en=0.
  - Exactly DEPTH entries are held, with no duplicated or lost addresses.
- Stall release: imem_en reasserts in the same cycle pop=1 (combinational credit).
- Jump in cycle J:
  - imem_en=0 in J.
  - J+1: inst_valid=0, imem_en=1, imem_addr=jump_addr.
  - J+3: first valid entry, with inst_addr=jump_addr.
- Back-to-back jumps: each jump flushes again; only the last target survives.
- rst asserted mid-cycle: all outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Free run: reset, memory model mem[a]=0x10+a, id_ready=1.
  - inst_valid rises 2 cycles after the first request.
  - inst_addr runs 0,1,2,…,15,0,1 (wrap) with inst 0x10,0x11,…; one per cycle, no gaps.
- Stall: free-run 3 cycles, then id_ready=0 for 10 cycles.
  - count settles at 4 and imem_en=0.
  - On release, inst_addr continues consecutively with no duplicate or skip.
- Jump flush: while the queue holds 3 entries and a read is in flight, pulse jump_flag with jump_addr=9.
  - Next cycle inst_valid=0 and imem_addr=9.
  - Stale response not delivered; first delivered inst_addr=9, inst=0x19, 3 cycles after the jump.
- Jump with simultaneous pop and full queue: jump_addr=2, id_ready=1.
  - Queue empty afterward; pc=2; the popped entry was consumed by decode only once.
- Back-to-back jumps: targets 5 then 12 on consecutive cycles.
  - The only delivered stream starts at inst_addr=12; address 5 never appears.
- Async reset mid-stream: assert rst between clock edges with the queue at 2 entries.
  - inst_valid=0, imem_en=0, imem_addr=0 immediately.
  - After release, the fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: jump redirect, instruction memory port and decode handshake.
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned INST_WIDTH = 8
);
  logic                  jump_flag;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_data;
  logic                  id_ready;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_addr;

  // Fetch unit side
  modport master (
    input  jump_flag, jump_addr, imem_data, id_ready,
    output imem_en, imem_addr, inst_valid, inst, inst_addr
  );

  // Environment side (memory, decode, mem-access stage)
  modport slave (
    output jump_flag, jump_addr, imem_data, id_ready,
    input  imem_en, imem_addr, inst_valid, inst, inst_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues reads to a synchronous
// instruction memory and buffers {inst, addr} pairs for decode.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned INST_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.master  bus
);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned CredW = CntW + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_issued_addr;
  logic                  r_inflight;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [CntW-1:0]       r_count;
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CredW-1:0]      w_credit;

  // Occupancy credit includes the in-flight read so a stalled queue never overflows
  always_comb begin
    w_valid  = (r_count != '0);
    w_pop    = w_valid & bus.id_ready;
    w_push   = r_inflight & ~bus.jump_flag;
    w_credit = CredW'(r_count) + CredW'(r_inflight) - CredW'(w_pop);
    w_issue  = ~rst & ~bus.jump_flag & (w_credit < CredW'(DEPTH));
  end

  assign bus.imem_en    = w_issue;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = r_inst_mem[r_rd_ptr];
  assign bus.inst_addr  = r_addr_mem[r_rd_ptr];

  // PC, in-flight tracking, pointers and count; a jump flushes and overrides any pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= '0;
      r_issued_addr <= '0;
      r_inflight    <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (bus.jump_flag) begin
      r_pc       <= bus.jump_addr;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_WIDTH'(1);
        r_issued_addr <= r_pc;
      end
      r_inflight <= w_issue;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; reset to zero so the head is deterministic while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_addr_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_inst_mem[r_wr_ptr] <= bus.imem_data;
      r_addr_mem[r_wr_ptr] <= r_issued_addr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: scoreboard of expected delivered addresses,
// decoupled monitor comparing each accepted head entry.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_WIDTH(4), .INST_WIDTH(8)) bus ();

  fetch_queue #(.ADDR_WIDTH(4), .INST_WIDTH(8), .DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad = 0;
  int seg_popped = 0;
  logic [3:0] exp_q[$];

  // Synchronous instruction memory: mem[a] = 0x10 + a
  initial bus.imem_data = 8'h00;
  always @(posedge clk) begin
    if (bus.imem_en === 1'b1) bus.imem_data <= 8'h10 + {4'h0, bus.imem_addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Restart the expected stream at address a (after reset release or jump)
  task automatic sb_restart(input logic [3:0] a);
    logic [3:0] v;
    v = a;
    exp_q.delete();
    seg_popped = 0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(v);
      v = v + 4'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must be the next expected address
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && bus.inst_valid === 1'b1 && bus.id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got addr %0h expected none", bus.inst_addr);
      end else begin
        e = exp_q.pop_front();
        chk("pop_addr", {28'h0, bus.inst_addr}, {28'h0, e});
        chk("pop_inst", {24'h0, bus.inst}, {24'h0, 8'h10 + {4'h0, e}});
        seg_popped++;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    logic [3:0] t;
    rst = 1'b1;
    bus.jump_flag = 1'b0;
    bus.jump_addr = 4'h0;
    bus.id_ready  = 1'b1;
    #12;
    chk("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("rst_inst", {24'h0, bus.inst}, 32'h0);
    chk("rst_inst_addr", {28'h0, bus.inst_addr}, 32'h0);
    chk("rst_imem_addr", {28'h0, bus.imem_addr}, 32'h0);
    chk("rst_imem_en", {31'h0, bus.imem_en}, 32'h0);

    // Free run with wrap
    tick();
    rst = 1'b0;
    sb_restart(4'h0);
    @(negedge clk);
    chk("first_en", {31'h0, bus.imem_en}, 32'h1);
    chk("first_addr", {28'h0, bus.imem_addr}, 32'h0);
    @(negedge clk);
    chk("lat_c1_valid", {31'h0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    chk("lat_c2_valid", {31'h0, bus.inst_valid}, 32'h1);
    tick();
    repeat (17) tick();
    chk("freerun_count", seg_popped, 32'd18);

    // Stall and release
    repeat (3) tick();
    bus.id_ready = 1'b0;
    p = seg_popped;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_en", {31'h0, bus.imem_en}, 32'h0);
    chk("stall_valid", {31'h0, bus.inst_valid}, 32'h1);
    t = bus.inst_addr + 4'd4;
    chk("stall_held4", {28'h0, bus.imem_addr}, {28'h0, t});
    chk("stall_nopop", seg_popped, p);
    tick();
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("release_en", {31'h0, bus.imem_en}, 32'h1);
    repeat (5) tick();

    // Jump flush with 3 entries queued and a read in flight
    bus.jump_flag = 1'b1;
    bus.jump_addr = 4'h9;
    @(negedge clk);
    chk("jump_en", {31'h0, bus.imem_en}, 32'h0);
    tick();
    bus.jump_flag = 1'b0;
    sb_restart(4'h9);
    @(negedge clk);
    chk("j1_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("j1_imem_addr", {28'h0, bus.imem_addr}, 32'h9);
    chk("j1_en", {31'h0, bus.imem_en}, 32'h1);
    @(negedge clk);
    chk("j2_valid", {31'h0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    chk("j3_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("j3_addr", {28'h0, bus.inst_addr}, 32'h9);
    chk("j3_inst", {24'h0, bus.inst}, 32'h19);
    tick();
    chk("j_first_pop", seg_popped, 32'd1);
    repeat (3) tick();

    // Jump with full queue and simultaneous pop
    bus.id_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("full_en", {31'h0, bus.imem_en}, 32'h0);
    tick();
    p = seg_popped;
    bus.id_ready  = 1'b1;
    bus.jump_flag = 1'b1;
    bus.jump_addr = 4'h2;
    tick();
    bus.jump_flag = 1'b0;
    chk("jpop_once", seg_popped, p + 1);
    sb_restart(4'h2);
    @(negedge clk);
    chk("jp1_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("jp1_imem_addr", {28'h0, bus.imem_addr}, 32'h2);
    @(negedge clk);
    @(negedge clk);
    chk("jp3_addr", {28'h0, bus.inst_addr}, 32'h2);
    repeat (4) tick();

    // Back-to-back jumps 5 then 12
    bus.jump_flag = 1'b1;
    bus.jump_addr = 4'h5;
    tick();
    bus.jump_addr = 4'hc;
    tick();
    bus.jump_flag = 1'b0;
    sb_restart(4'hc);
    @(negedge clk);
    chk("bb2_imem_addr", {28'h0, bus.imem_addr}, 32'hc);
    chk("bb2_valid", {31'h0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    chk("bb3_valid", {31'h0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    chk("bb4_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("bb4_addr", {28'h0, bus.inst_addr}, 32'hc);

    // Async reset mid-cycle with two entries queued
    tick();
    bus.id_ready = 1'b0;
    tick();
    chk("pre_rst_valid", {31'h0, bus.inst_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("arst_en", {31'h0, bus.imem_en}, 32'h0);
    chk("arst_imem_addr", {28'h0, bus.imem_addr}, 32'h0);
    chk("arst_inst", {24'h0, bus.inst}, 32'h0);
    chk("arst_inst_addr", {28'h0, bus.inst_addr}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.id_ready = 1'b1;
    sb_restart(4'h0);
    @(negedge clk);
    chk("rr_en", {31'h0, bus.imem_en}, 32'h1);
    chk("rr_addr", {28'h0, bus.imem_addr}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("rr_inst_addr", {28'h0, bus.inst_addr}, 32'h0);
    repeat (6) tick();
    chk("rr_count", seg_popped, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
